sequence_player: RTL and testbench
==================================

SEQUENCE_PLAYER -- requirements
Module: sequence_player

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, giving the maximum sequence length (entries held).
REQ-002 SHALL have parameter SEED, default 8'hA5, giving the LFSR reset value (nonzero).
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port new_game  in  1  single-cycle request to regenerate the sequence.
REQ-006 SHALL have port start_play  in  1  single-cycle request to play back the first len entries.
REQ-007 SHALL have port len  in  5  number of entries to play; values above MAX_LEN clamp to MAX_LEN.
REQ-008 SHALL have port timerout  in  1  tick from downstream counter25 marking end of one phase.
REQ-009 SHALL have port timer_en  out  1  drives counter25 en.
REQ-010 SHALL have port timer_clr  out  1  drives counter25 reset; one-cycle pulse restarting the phase timer.
REQ-011 SHALL have port led  out  4  one-hot LED drive for the current entry, 4'b0000 when dark.
REQ-012 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port done  out  1  one-cycle pulse when playback finishes.
REQ-014 SHALL have port rd_addr  in  4  checker read address; rd_data  out  2  registered entry value, 1-cycle latency.

Function
REQ-015 SHALL implement states IDLE, GEN, SHOW, GAP, FIN.
REQ-016 SHALL, in IDLE with new_game=1, enter GEN; new_game takes priority over a simultaneous start_play.
REQ-017 SHALL, in GEN, write one entry per cycle at addresses 0..MAX_LEN-1 (MAX_LEN cycles), entry = lfsr[1:0] after stepping, then return to IDLE.
REQ-018 SHALL step the 8-bit LFSR only in GEN: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-019 SHALL, in IDLE with start_play=1 and clamped len=0, pulse done the next cycle without visiting SHOW.
REQ-020 SHALL, in IDLE with start_play=1 and len>0, latch clamped len, clear index to 0, pulse timer_clr, and enter SHOW.
REQ-021 SHALL, in SHOW, drive led = 1 << entry[index] and timer_en=1.
REQ-022 SHALL, on timerout in SHOW, pulse timer_clr and enter GAP (macro set) or advance directly (macro clear).
REQ-023 SHALL, on advance with index = latched_len-1, enter FIN; otherwise increment index, pulse timer_clr, and enter SHOW.
REQ-024 SHALL, in FIN, drive led=0 and timer_en=0, pulse done for one cycle, and return to IDLE.
REQ-025 SHALL ignore new_game and start_play while busy=1.
REQ-026 SHALL ignore timerout outside SHOW/GAP.
REQ-027 SHALL keep led=0 and timer_en=0 in IDLE, GEN, and FIN.
REQ-028 SHALL return rd_data = entry[rd_addr] one cycle after rd_addr is presented, in any state; addresses >= MAX_LEN return 2'b00.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, force state IDLE, lfsr=SEED, index=0, led=0, timer_en=0, timer_clr=1 (single cycle), busy=0, done=0, rd_data=0, and all entries=0.
REQ-030 SHALL let reset asserted mid-GEN or mid-SHOW abort immediately without producing a done pulse.

Configuration
REQ-031 SHALL, with macro SEQUENCE_PLAYER_GAP_EN defined, insert a GAP phase (led=0, timer_en=1, lasting one timer period) after each SHOW, advancing on the timerout that ends the GAP.
REQ-032 SHALL, without SEQUENCE_PLAYER_GAP_EN, omit the GAP state entirely, so consecutive entries are shown back-to-back with a timer_clr pulse between them.

Verification
REQ-033 SHALL cover: reset, then new_game -> busy high for exactly 16 cycles, rd_data at addresses 0..15 equals the REQ-018 model seeded with 8'hA5.
REQ-034 SHALL cover: start_play with len=3 and a timerout every 25 cycles -> 3 one-hot led values in entry order, GAP dark periods when the macro is set, then exactly one done pulse.
REQ-035 SHALL cover: start_play with len=0 -> done the next cycle, led stays 0, and timer_en is never asserted.
REQ-036 SHALL cover: start_play with len=20 -> exactly 16 entries shown.
REQ-037 SHALL cover: new_game and start_play pulsed together in IDLE -> GEN entered; start_play pulsed during SHOW -> no effect.
REQ-038 SHALL cover: reset asserted during the second SHOW -> next cycle IDLE, led=0, no done pulse, and rd_data=0 for all addresses.

Source files
------------

// File: rtl/sequence_player.sv
// Plays back a pseudo-random 2-bit sequence as one-hot LED pulses timed by an external counter.
// Optional GAP phase between entries is enabled with `define SEQUENCE_PLAYER_GAP_EN.
module sequence_player #(
   parameter int         MAX_LEN = 16,
   parameter logic [7:0] SEED    = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       new_game,
   input  logic       start_play,
   input  logic [4:0] len,
   input  logic       timerout,
   output logic       timer_en,
   output logic       timer_clr,
   output logic [3:0] led,
   output logic       busy,
   output logic       done,
   input  logic [3:0] rd_addr,
   output logic [1:0] rd_data,
   output logic [2:0] state_dbg
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      GEN  = 3'd1,
      SHOW = 3'd2,
      FIN  = 3'd3
`ifdef SEQUENCE_PLAYER_GAP_EN
      ,GAP = 3'd4
`endif
   } state_t;

   state_t           state, state_next;
   logic [7:0]       lfsr;
   logic [7:0]       lfsr_step;
   logic [IDX_W-1:0] index;
   logic [4:0]       len_q;
   logic [4:0]       len_clamped;
   logic [1:0]       entry [MAX_LEN];

   logic clr_req, load, idx_clr, idx_inc, gen_we, advance;
   logic gen_last, play_last;

   assign lfsr_step   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign len_clamped = (int'(len) > MAX_LEN) ? 5'(MAX_LEN) : len;
   assign gen_last    = (index == IDX_W'(MAX_LEN - 1));
   assign play_last   = (5'(index) == (len_q - 5'd1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Request inputs are only looked at in IDLE; timerout only in the timed phases.
   always_comb begin
      state_next = state;
      clr_req    = 1'b0;
      load       = 1'b0;
      idx_clr    = 1'b0;
      idx_inc    = 1'b0;
      gen_we     = 1'b0;
      advance    = 1'b0;
      case (state)
         IDLE: begin
            if (new_game) begin
               state_next = GEN;
               idx_clr    = 1'b1;
            end else if (start_play) begin
               if (len_clamped == 5'd0) begin
                  state_next = FIN;
               end else begin
                  state_next = SHOW;
                  load       = 1'b1;
                  idx_clr    = 1'b1;
                  clr_req    = 1'b1;
               end
            end
         end
         GEN: begin
            gen_we = 1'b1;
            if (gen_last) state_next = IDLE;
         end
         SHOW: begin
            if (timerout) begin
`ifdef SEQUENCE_PLAYER_GAP_EN
               clr_req    = 1'b1;
               state_next = GAP;
`else
               advance    = 1'b1;
`endif
            end
         end
`ifdef SEQUENCE_PLAYER_GAP_EN
         GAP: begin
            if (timerout) advance = 1'b1;
         end
`endif
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (advance) begin
         if (play_last) begin
            state_next = FIN;
         end else begin
            idx_inc    = 1'b1;
            clr_req    = 1'b1;
            state_next = SHOW;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr      <= SEED;
         index     <= '0;
         len_q     <= 5'd0;
         timer_clr <= 1'b1;
         rd_data   <= 2'b00;
         for (int i = 0; i < MAX_LEN; i++) entry[i] <= 2'b00;
      end else begin
         timer_clr <= clr_req;
         if (idx_clr)                index <= '0;
         else if (idx_inc || gen_we) index <= index + IDX_W'(1);
         if (load) len_q <= len_clamped;
         if (gen_we) begin
            lfsr         <= lfsr_step;
            entry[index] <= lfsr_step[1:0];
         end
         rd_data <= (int'(rd_addr) < MAX_LEN) ? entry[rd_addr] : 2'b00;
      end
   end

   assign led       = (state == SHOW) ? (4'b0001 << entry[index]) : 4'b0000;
`ifdef SEQUENCE_PLAYER_GAP_EN
   assign timer_en  = (state == SHOW) || (state == GAP);
`else
   assign timer_en  = (state == SHOW);
`endif
   assign busy      = (state != IDLE);
   assign done      = (state == FIN);
   assign state_dbg = state;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player: generation, playback, clamping, request priority and reset abort.
module tb_sequence_player;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       new_game = 1'b0;
   logic       start_play = 1'b0;
   logic [4:0] len = 5'd0;
   logic       timerout = 1'b0;
   logic       timer_en, timer_clr, busy, done;
   logic [3:0] led;
   logic [3:0] rd_addr = 4'd0;
   logic [1:0] rd_data;
   logic [2:0] state_dbg;

`ifdef SEQUENCE_PLAYER_GAP_EN
   localparam int GAPS_PER = 1;
`else
   localparam int GAPS_PER = 0;
`endif

   int errors = 0;
   int checks = 0;

   logic [7:0] mlfsr = 8'hA5;
   logic [1:0] exp_entry [16];
   logic [3:0] exp_q [$];
   logic [3:0] shown_led [32];
   int n_shown, n_gaps, n_done, n_en, n_led_on, first_done;
   bit aborted;

   sequence_player dut (
      .clk(clk), .reset(reset), .new_game(new_game), .start_play(start_play),
      .len(len), .timerout(timerout), .timer_en(timer_en), .timer_clr(timer_clr),
      .led(led), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   task automatic model_gen();
      for (int i = 0; i < 16; i++) begin
         mlfsr        = step(mlfsr);
         exp_entry[i] = mlfsr[1:0];
      end
   endtask

   // Acts as the downstream 25-cycle phase counter while a playback runs.
   task automatic play(input logic [4:0] l, input bit poke, input int abort_after);
      int ph = 0;
      int cyc = 0;
      n_shown = 0; n_gaps = 0; n_done = 0; n_en = 0; n_led_on = 0;
      first_done = -1; aborted = 0;
      len = l; start_play = 1'b1;
      tick();
      start_play = 1'b0;
      while (busy && cyc < 3000) begin
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = cyc;
         end
         if (timer_en) n_en++;
         if (led != 4'b0000) n_led_on++;
         if (timer_clr) ph = 0;
         else if (timer_en) ph = ph + 1;
         if (abort_after > 0 && (n_shown + n_gaps) == abort_after && led != 4'b0000 && ph == 5) begin
            reset = 1'b1;
            tick();
            aborted = 1;
            return;
         end
         timerout = timer_en && (ph == 24);
         if (timerout) begin
            if (led != 4'b0000) begin
               shown_led[n_shown] = led;
               n_shown++;
            end else begin
               n_gaps++;
            end
         end
         if (poke && n_shown == 0 && ph == 10) begin
            start_play = 1'b1; new_game = 1'b1; len = 5'd0;
         end
         tick();
         timerout = 1'b0; start_play = 1'b0; new_game = 1'b0;
         cyc++;
      end
      checks++;
      if (cyc >= 3000) begin
         errors++;
         $display("FAIL play_timeout: busy still %0b after %0d cycles, required idle", busy, cyc);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
      checks++; if (led !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b want 0000", led); end
      checks++; if (timer_en !== 1'b0) begin errors++; $display("FAIL reset_timer_en: got %0b want 0", timer_en); end
      checks++; if (timer_clr !== 1'b1) begin errors++; $display("FAIL reset_timer_clr: got %0b want 1", timer_clr); end
      checks++; if (rd_data !== 2'b00) begin errors++; $display("FAIL reset_rd_data: got %0d want 0", rd_data); end
      reset = 1'b0;
      tick();
      checks++; if (timer_clr !== 1'b0) begin errors++; $display("FAIL reset_clr_release: got %0b want 0", timer_clr); end
   endtask

   task automatic test_generate(input bit with_start);
      int n = 0;
      new_game = 1'b1;
      start_play = with_start;
      len = 5'd3;
      tick();
      new_game = 1'b0; start_play = 1'b0;
      while (busy && n < 100) begin
         if (led !== 4'b0000 || timer_en !== 1'b0) begin
            checks++; errors++;
            $display("FAIL gen_dark: led=%b timer_en=%0b want 0000/0", led, timer_en);
         end
         n++;
         tick();
      end
      checks++; if (n != 16) begin errors++; $display("FAIL gen_busy_cycles: got %0d want 16", n); end
      model_gen();
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         tick();
         checks++;
         if (rd_data !== exp_entry[a]) begin
            errors++;
            $display("FAIL gen_rd_data[%0d]: got %0d want %0d", a, rd_data, exp_entry[a]);
         end
      end
   endtask

   task automatic test_play_len3();
      logic [3:0] want [3];
      want[0] = 4'b0100; want[1] = 4'b0010; want[2] = 4'b0100;
      play(5'd3, 1'b0, 0);
      checks++; if (n_shown != 3) begin errors++; $display("FAIL len3_count: got %0d want 3", n_shown); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (shown_led[i] !== want[i]) begin
            errors++; $display("FAIL len3_led[%0d]: got %b want %b", i, shown_led[i], want[i]);
         end
      end
      checks++; if (n_gaps != 3 * GAPS_PER) begin errors++; $display("FAIL len3_gaps: got %0d want %0d", n_gaps, 3 * GAPS_PER); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL len3_done: got %0d want 1", n_done); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL len3_done_after: got %0b want 0", done); end
   endtask

   task automatic test_len0();
      play(5'd0, 1'b0, 0);
      checks++; if (first_done != 0) begin errors++; $display("FAIL len0_done_cycle: got %0d want 0", first_done); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL len0_done_count: got %0d want 1", n_done); end
      checks++; if (n_en != 0) begin errors++; $display("FAIL len0_timer_en: got %0d cycles want 0", n_en); end
      checks++; if (n_led_on != 0) begin errors++; $display("FAIL len0_led: got %0d lit cycles want 0", n_led_on); end
      timerout = 1'b1;
      tick();
      timerout = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_timerout: busy=%0b want 0", busy); end
   endtask

   task automatic test_clamp();
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(4'b0001 << exp_entry[i]);
      play(5'd20, 1'b0, 0);
      checks++; if (n_shown != 16) begin errors++; $display("FAIL clamp_count: got %0d want 16", n_shown); end
      for (int i = 0; i < n_shown && i < 16; i++) begin
         logic [3:0] e;
         e = exp_q.pop_front();
         checks++;
         if (shown_led[i] !== e) begin
            errors++; $display("FAIL clamp_led[%0d]: got %b want %b", i, shown_led[i], e);
         end
      end
      checks++; if (n_done != 1) begin errors++; $display("FAIL clamp_done: got %0d want 1", n_done); end
   endtask

   task automatic test_busy_ignore();
      play(5'd2, 1'b1, 0);
      checks++; if (n_shown != 2) begin errors++; $display("FAIL ignore_count: got %0d want 2", n_shown); end
      checks++; if (shown_led[0] !== 4'b0100) begin errors++; $display("FAIL ignore_led0: got %b want 0100", shown_led[0]); end
      checks++; if (shown_led[1] !== 4'b0010) begin errors++; $display("FAIL ignore_led1: got %b want 0010", shown_led[1]); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL ignore_done: got %0d want 1", n_done); end
   endtask

   task automatic test_reset_mid_show();
      int dones = 0;
      play(5'd3, 1'b0, 1 + GAPS_PER);
      checks++; if (!aborted) begin errors++; $display("FAIL abort_reached: got %0b want 1", aborted); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", busy); end
      checks++; if (led !== 4'b0000) begin errors++; $display("FAIL abort_led: got %b want 0000", led); end
      checks++; if (timer_en !== 1'b0) begin errors++; $display("FAIL abort_timer_en: got %0b want 0", timer_en); end
      reset = 1'b0;
      for (int a = 0; a < 16; a++) begin
         if (done) dones++;
         rd_addr = 4'(a);
         tick();
         checks++;
         if (rd_data !== 2'b00) begin
            errors++; $display("FAIL abort_rd_data[%0d]: got %0d want 0", a, rd_data);
         end
      end
      checks++; if (dones != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", dones); end
   endtask

   initial begin
      test_reset();
      test_generate(1'b0);
      test_play_len3();
      test_len0();
      test_clamp();
      test_busy_ignore();
      test_generate(1'b1);
      test_reset_mid_show();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
